trivium_prng: RTL and testbench

- Keystream generator that feeds the seed expander; sits directly upstream of it.
- Accepts a 256-bit seed through a reseed/reseed_ack handshake and folds it into an 80-bit Trivium key and an 80-bit IV.
- Runs the 1152-round Trivium warm-up, then delivers 128-bit keystream blocks over a valid/ready interface (rdi_data/rdi_valid/rdi_ready).

---
 rtl/newhope_prng_pkg.sv | 59 +++++
 rtl/trivium_prng_if.sv | 38 +++
 rtl/trivium_core.sv | 55 +++++
 rtl/trivium_prng.sv | 151 +++++++++++++++
 tb/tb_trivium_prng.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/newhope_prng_pkg.sv
// -----------------------------------------------------------------------------
// newhope_prng_pkg
//   Shared constants, FSM state encoding and seed-fold helpers for the Trivium
//   keystream generator that sits directly upstream of the seed expander.
//
//   Contents:
//     TRIV_STATE_W / TRIV_KEY_W / TRIV_IV_W  Trivium register, key and IV widths
//     WARMUP_ROUNDS / BLOCK_W                warm-up length and keystream block size
//     SEED_W                                 width of the consumer-supplied seed
//     prng_state_e                           FSM states (encodings as localparams)
//     triv_seed_t, fold_seed(), triv_load()  seed -> key/IV -> initial state
// -----------------------------------------------------------------------------
package newhope_prng_pkg;

    localparam int TRIV_STATE_W  = 288;
    localparam int TRIV_KEY_W    = 80;
    localparam int TRIV_IV_W     = 80;
    localparam int WARMUP_ROUNDS = 1152;
    localparam int BLOCK_W       = 128;
    localparam int SEED_W        = 256;

    localparam logic [1:0] ST_UNSEEDED_ENC = 2'd0;
    localparam logic [1:0] ST_WARMUP_ENC   = 2'd1;
    localparam logic [1:0] ST_GEN_ENC      = 2'd2;
    localparam logic [1:0] ST_VALID_ENC    = 2'd3;

    typedef enum logic [1:0] {
        ST_UNSEEDED = ST_UNSEEDED_ENC,
        ST_WARMUP   = ST_WARMUP_ENC,
        ST_GEN      = ST_GEN_ENC,
        ST_VALID    = ST_VALID_ENC
    } prng_state_e;

    typedef struct packed {
        logic [TRIV_KEY_W-1:0] key;
        logic [TRIV_IV_W-1:0]  iv;
    } triv_seed_t;

    // The 256-bit seed is compressed into an 80-bit key and an 80-bit IV; the
    // top 16 seed bits only reach the low end of the IV.
    function automatic triv_seed_t fold_seed(input logic [SEED_W-1:0] seed);
        triv_seed_t f;
        f.key = seed[79:0] ^ seed[239:160];
        f.iv  = seed[159:80] ^ {64'b0, seed[255:240]};
        return f;
    endfunction

    // Standard Trivium load with s1 at bit 0: key in s1..s80, IV in s94..s173,
    // s286..s288 set, everything else clear.
    function automatic logic [TRIV_STATE_W-1:0] triv_load(input triv_seed_t ki);
        logic [TRIV_STATE_W-1:0] s;
        s          = '0;
        s[79:0]    = ki.key;
        s[172:93]  = ki.iv;
        s[287:285] = 3'b111;
        return s;
    endfunction

endpackage

// File: rtl/trivium_prng_if.sv
// -----------------------------------------------------------------------------
// trivium_prng_if
//   Reseed handshake plus keystream valid/ready channel between the Trivium
//   generator and the seed expander.
//
//   Signals:
//     seed[255:0]      seed value, sampled on the reseed rising edge
//     reseed           reseed request level, held by the consumer until after ack
//     reseed_ack       one-cycle pulse when warm-up is complete
//     rdi_data[127:0]  current keystream block, stable while rdi_valid=1
//     rdi_valid        block available
//     rdi_ready        consumer pops the block
//
//   Modports:
//     master  the generator (drives ack and the keystream channel)
//     slave   the consumer  (drives seed, reseed and rdi_ready)
// -----------------------------------------------------------------------------
interface trivium_prng_if;
    import newhope_prng_pkg::*;

    logic [SEED_W-1:0]  seed;
    logic               reseed;
    logic               reseed_ack;
    logic [BLOCK_W-1:0] rdi_data;
    logic               rdi_valid;
    logic               rdi_ready;

    modport master (
        input  seed, reseed, rdi_ready,
        output reseed_ack, rdi_data, rdi_valid
    );

    modport slave (
        output seed, reseed, rdi_ready,
        input  reseed_ack, rdi_data, rdi_valid
    );

endinterface

// File: rtl/trivium_core.sv
// -----------------------------------------------------------------------------
// trivium_core
//   Purely combinational W-round Trivium update. Rounds are chained oldest
//   first, so z[0] is the first keystream bit produced this cycle.
//
//   Ports:
//     state_in[287:0]   current Trivium state (bit 0 = s1)
//     state_out[287:0]  state after W rounds
//     z[W-1:0]          keystream bits of those W rounds
// -----------------------------------------------------------------------------
module trivium_core
    import newhope_prng_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [TRIV_STATE_W-1:0] state_in,
    output logic [TRIV_STATE_W-1:0] state_out,
    output logic [W-1:0]            z
);

    logic [TRIV_STATE_W-1:0] s;
    logic                    t1;
    logic                    t2;
    logic                    t3;

    always_comb begin
        // NOTE: every variable gets a value before any branch or loop so the
        // block stays purely combinational and no latch is inferred.
        s  = state_in;
        z  = '0;
        t1 = 1'b0;
        t2 = 1'b0;
        t3 = 1'b0;
        // NOTE: blocking assignments are intentional here; each round must see
        // the state left by the previous round within the same cycle.
        for (int r = 0; r < W; r++) begin
            t1   = s[65]  ^ s[92];
            t2   = s[161] ^ s[176];
            t3   = s[242] ^ s[287];
            z[r] = t1 ^ t2 ^ t3;
            t1   = t1 ^ (s[90]  & s[91])  ^ s[170];
            t2   = t2 ^ (s[174] & s[175]) ^ s[263];
            t3   = t3 ^ (s[285] & s[286]) ^ s[68];
            // One-position shift of all three registers; the feedback bits
            // overwrite the heads s1, s94 and s178 (the old tails s93, s177,
            // s288 fall off).
            s      = {s[286:0], 1'b0};
            s[0]   = t3;
            s[93]  = t1;
            s[177] = t2;
        end
        state_out = s;
    end

endmodule

// File: rtl/trivium_prng.sv
// -----------------------------------------------------------------------------
// trivium_prng
//   Trivium keystream generator. A rising edge on reseed folds the 256-bit seed
//   into key/IV, loads the state and runs the 1152-round warm-up; afterwards
//   128-bit blocks are produced W bits per clock and offered on rdi_*.
//
//   Ports:
//     clk   clock
//     rst   synchronous, active-high reset
//     bus   trivium_prng_if.master (seed/reseed/reseed_ack, rdi_data/valid/ready)
//
//   Parameter W: rounds per clock; 1, 2, 4, 8, 16, 32 or 64 (divides 128, 1152).
// -----------------------------------------------------------------------------
module trivium_prng
    import newhope_prng_pkg::*;
#(
    parameter int W = 32
) (
    input  logic              clk,
    input  logic              rst,
    trivium_prng_if.master    bus
);

    localparam int WARMUP_STEPS = WARMUP_ROUNDS / W;
    localparam int GEN_STEPS    = BLOCK_W / W;
    localparam int CNT_W        = $clog2(WARMUP_STEPS + 1);
    localparam int IDX_W        = $clog2(GEN_STEPS);

    localparam logic [CNT_W-1:0] WARMUP_LAST = CNT_W'(WARMUP_STEPS - 1);
    localparam logic [CNT_W-1:0] GEN_LAST    = CNT_W'(GEN_STEPS - 1);

    prng_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TRIV_STATE_W-1:0] triv_q, triv_d;
    logic [TRIV_STATE_W-1:0] core_out;
    logic [W-1:0]            core_z;
    logic [BLOCK_W-1:0]      acc_q, acc_d;
    logic [BLOCK_W-1:0]      block_next;
    logic [BLOCK_W-1:0]      data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ack_q, ack_d;
    logic                    reseed_q;
    logic                    request;
    logic [IDX_W-1:0]        gen_idx;

    trivium_core #(.W(W)) u_core (
        .state_in  (triv_q),
        .state_out (core_out),
        .z         (core_z)
    );

    // Only the rising edge is a request; the consumer keeps reseed high one
    // cycle past the ack and that must not restart the warm-up.
    assign request = bus.reseed & ~reseed_q;

    // During GEN the step counter selects which W-bit slice of the block the
    // current keystream bits land in; the first generated bit ends up in bit 0.
    assign gen_idx = cnt_q[IDX_W-1:0];

    always_comb begin
        block_next                 = acc_q;
        block_next[gen_idx*W +: W] = core_z;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        triv_d  = triv_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = valid_q;
        ack_d   = 1'b0;

        unique case (state_q)
            ST_UNSEEDED: begin
                // Idle until the first seed; rdi_ready is ignored.
            end
            ST_WARMUP: begin
                triv_d = core_out;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == WARMUP_LAST) begin
                    ack_d   = 1'b1;
                    state_d = ST_GEN;
                    cnt_d   = '0;
                end
            end
            ST_GEN: begin
                triv_d = core_out;
                acc_d  = block_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == GEN_LAST) begin
                    // rdi_data only changes once the whole block is ready.
                    data_d  = block_next;
                    valid_d = 1'b1;
                    state_d = ST_VALID;
                    cnt_d   = '0;
                end
            end
            ST_VALID: begin
                // Trivium state is frozen until the block is consumed.
                if (bus.rdi_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_GEN;
                end
            end
            default: begin
                state_d = ST_UNSEEDED;
            end
        endcase

        // A reseed edge overrides everything above, including a same-cycle pop
        // and a final warm-up step: the old seed's block and ack are dropped.
        if (request) begin
            triv_d  = triv_load(fold_seed(bus.seed));
            state_d = ST_WARMUP;
            cnt_d   = '0;
            acc_d   = '0;
            valid_d = 1'b0;
            ack_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= ST_UNSEEDED;
            cnt_q    <= '0;
            triv_q   <= '0;
            acc_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ack_q    <= 1'b0;
            reseed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            triv_q   <= triv_d;
            acc_q    <= acc_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ack_q    <= ack_d;
            reseed_q <= bus.reseed;
        end
    end

    assign bus.rdi_data   = data_q;
    assign bus.rdi_valid  = valid_q;
    assign bus.reseed_ack = ack_q;

endmodule

// File: tb/tb_trivium_prng.sv
// -----------------------------------------------------------------------------
// tb_trivium_prng
//   Directed bench for trivium_prng (W=32). Expected keystream comes from a
//   bit-serial Trivium reference written over a 1-indexed s1..s288 array, plus
//   the published key=0/IV=0 block.
// -----------------------------------------------------------------------------
module tb_trivium_prng;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    trivium_prng_if bus ();

    trivium_prng #(.W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [127:0] KAT_ZERO = 128'h7FC99F23_4E2E7A51_1B055958_26BFE0FB;

    int checks   = 0;
    int failures = 0;
    bit m [1:288];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    task automatic model_round(output bit z);
        bit t1, t2, t3;
        t1 = m[66]  ^ m[93];
        t2 = m[162] ^ m[177];
        t3 = m[243] ^ m[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (m[91]  & m[92])  ^ m[171];
        t2 = t2 ^ (m[175] & m[176]) ^ m[264];
        t3 = t3 ^ (m[286] & m[287]) ^ m[69];
        for (int i = 93;  i >= 2;   i--) m[i] = m[i-1];
        m[1] = t3;
        for (int i = 177; i >= 95;  i--) m[i] = m[i-1];
        m[94] = t1;
        for (int i = 288; i >= 179; i--) m[i] = m[i-1];
        m[178] = t2;
    endtask

    task automatic model_start(input logic [79:0] key, input logic [79:0] iv);
        bit z;
        for (int i = 1;  i <= 288; i++) m[i] = 1'b0;
        for (int i = 1;  i <= 80;  i++) m[i] = key[i-1];
        for (int i = 94; i <= 173; i++) m[i] = iv[i-94];
        m[286] = 1'b1;
        m[287] = 1'b1;
        m[288] = 1'b1;
        repeat (1152) model_round(z);
    endtask

    task automatic model_seed(input logic [255:0] sd);
        model_start(sd[79:0] ^ sd[239:160], sd[159:80] ^ {64'b0, sd[255:240]});
    endtask

    task automatic model_block(output logic [127:0] blk);
        bit z;
        blk = '0;
        for (int k = 0; k < 128; k++) begin
            model_round(z);
            blk[k] = z;
        end
    endtask

    // ---------------- protocol helpers ----------------
    // Assumes reseed was just raised; counts edges to the ack, then to rdi_valid.
    task automatic run_to_valid(input string tag, input bit stray_ready,
                                output int lat_ack, output int lat_valid);
        lat_ack = 0;
        do begin
            tick();
            lat_ack++;
        end while (!bus.reseed_ack && lat_ack < 100);
        lat_valid = 0;
        do begin
            tick();
            lat_valid++;
            if (lat_valid == 1) begin
                check({tag, "_ack_pulse"}, 128'(bus.reseed_ack), 128'd0);
                bus.reseed = 1'b0;
            end
            if (stray_ready) bus.rdi_ready = (lat_valid == 1 || lat_valid == 2);
        end while (!bus.rdi_valid && lat_valid < 100);
        bus.rdi_ready = 1'b0;
    endtask

    task automatic expect_seed(input string tag, input logic [255:0] sd, input bit stray);
        int la, lv;
        logic [127:0] exp;
        bus.seed   = sd;
        bus.reseed = 1'b1;
        run_to_valid(tag, stray, la, lv);
        check({tag, "_ack_lat"},   128'(la), 128'd37);
        check({tag, "_valid_lat"}, 128'(lv), 128'd4);
        model_seed(sd);
        model_block(exp);
        check({tag, "_block0"}, bus.rdi_data, exp);
    endtask

    initial begin
        logic [127:0] exp;
        logic [127:0] prev;
        int low, acks, ack_at, n, la, lv;
        bit seen;

        rst           = 1'b1;
        bus.seed      = '0;
        bus.reseed    = 1'b0;
        bus.rdi_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", 128'(bus.rdi_valid), 128'd0);
        check("rst_ack",   128'(bus.reseed_ack), 128'd0);
        check("rst_data",  bus.rdi_data, 128'd0);
        rst = 1'b0;
        tick();

        // Zero seed: key=0, IV=0 known answer.
        expect_seed("kat", 256'd0, 1'b0);
        check("kat_const", bus.rdi_data, KAT_ZERO);

        // Continuity over the following blocks (model continues from block 0).
        for (int b = 1; b <= 4; b++) begin
            prev = bus.rdi_data;
            tick();
            check("hold_valid", 128'(bus.rdi_valid), 128'd1);
            check("hold_data", bus.rdi_data, prev);
            bus.rdi_ready = 1'b1;
            tick();
            bus.rdi_ready = 1'b0;
            low = 0;
            while (!bus.rdi_valid && low < 50) begin
                low++;
                tick();
            end
            check("gap_cycles", 128'(low), 128'd4);
            model_block(exp);
            check("cont_block", bus.rdi_data, exp);
        end

        // Consumer holds reseed high for 40 cycles: one ack, no second warm-up.
        bus.seed   = {256{1'b1}};
        bus.reseed = 1'b1;
        acks   = 0;
        ack_at = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.reseed_ack) begin
                acks++;
                ack_at = i;
            end
        end
        bus.reseed = 1'b0;
        n = 40;
        while (!bus.rdi_valid && n < 100) begin
            tick();
            n++;
            if (bus.reseed_ack) acks++;
        end
        check("hold_acks",   128'(acks), 128'd1);
        check("hold_ack_at", 128'(ack_at), 128'd37);
        check("hold_valid_at", 128'(n), 128'd41);
        model_start(80'd0, 80'hFFFF_FFFF_FFFF_FFFF_0000);
        model_block(exp);
        check("ones_block0", bus.rdi_data, exp);

        // Abort: second reseed edge 20 cycles into the first warm-up.
        bus.seed   = 256'h01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        bus.reseed = 1'b1;
        tick();
        tick();
        bus.reseed = 1'b0;
        repeat (18) tick();
        expect_seed("abort", {4{64'hDEADBEEF_CAFEF00D}}, 1'b0);

        // Reseed and pop in the same cycle while VALID: reseed wins.
        bus.seed      = {8{32'h13579BDF}};
        bus.reseed    = 1'b1;
        bus.rdi_ready = 1'b1;
        tick();
        bus.rdi_ready = 1'b0;
        check("rs_pop_valid", 128'(bus.rdi_valid), 128'd0);
        run_to_valid("rs_pop", 1'b0, la, lv);
        check("rs_pop_ack_lat",   128'(la + 1), 128'd37);
        check("rs_pop_valid_lat", 128'(lv), 128'd4);
        model_seed({8{32'h13579BDF}});
        model_block(exp);
        check("rs_pop_block0", bus.rdi_data, exp);

        // Stray ready while UNSEEDED and during GEN.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.rdi_ready = 1'b1;
        repeat (3) tick();
        bus.rdi_ready = 1'b0;
        check("stray_unseeded", 128'(bus.rdi_valid), 128'd0);
        expect_seed("stray", {2{128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_6969_9696}}, 1'b1);
        prev = bus.rdi_data;
        tick();
        check("stray_no_pop_valid", 128'(bus.rdi_valid), 128'd1);
        check("stray_no_pop_data", bus.rdi_data, prev);

        // Reset in the middle of GEN.
        bus.rdi_ready = 1'b1;
        tick();
        bus.rdi_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 128'(bus.rdi_valid), 128'd0);
        check("midrst_ack",   128'(bus.reseed_ack), 128'd0);
        seen = 1'b0;
        repeat (60) begin
            tick();
            if (bus.rdi_valid || bus.reseed_ack) seen = 1'b1;
        end
        check("midrst_quiet", 128'(seen), 128'd0);

        // Reseed already high when reset releases counts as an edge.
        rst        = 1'b1;
        bus.seed   = {16{16'hC0DE}};
        bus.reseed = 1'b1;
        tick();
        rst = 1'b0;
        run_to_valid("rel", 1'b0, la, lv);
        check("rel_ack_lat",   128'(la), 128'd37);
        check("rel_valid_lat", 128'(lv), 128'd4);
        model_seed({16{16'hC0DE}});
        model_block(exp);
        check("rel_block0", bus.rdi_data, exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
